// File: rtl/mac_dot_seq.sv
// mac_dot_seq: runs a dot product on mac_top by fetching operand pairs from two
// synchronous-read memories and returning the final accumulator over valid/ready.
module mac_dot_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 9,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_base_a,
  input  logic [ADDR_WIDTH-1:0] cmd_base_b,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  abort,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr_a,
  output logic [ADDR_WIDTH-1:0] mem_addr_b,
  input  logic [DATA_WIDTH-1:0] mem_rdata_a,
  input  logic [DATA_WIDTH-1:0] mem_rdata_b,
  output logic                  mac_start,
  output logic                  mac_clr_acc,
  output logic [DATA_WIDTH-1:0] mac_a,
  output logic [DATA_WIDTH-1:0] mac_b,
  input  logic                  mac_ready,
  input  logic [ACC_WIDTH-1:0]  mac_acc,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [ACC_WIDTH-1:0]  result_data,
  output logic                  result_err,
  output logic                  busy
);
  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, LOAD, START, WAIT, SETTLE, DONE} state_t;
  localparam int WW = $clog2(TIMEOUT + 1);
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_a_q, base_a_d, base_b_q, base_b_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d, idx_q, idx_d;
  logic [WW-1:0]         wcnt_q, wcnt_d;
  logic                  err_q, err_d, res_err_q, res_err_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [ACC_WIDTH-1:0]  res_q, res_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      base_a_q  <= '0;
      base_b_q  <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      wcnt_q    <= '0;
      err_q     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      res_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_a_q  <= base_a_d;
      base_b_q  <= base_b_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      wcnt_q    <= wcnt_d;
      err_q     <= err_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      res_err_q <= res_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    base_a_d  = base_a_q;
    base_b_d  = base_b_q;
    len_d     = len_q;
    idx_d     = idx_q;
    wcnt_d    = '0;
    err_d     = err_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    res_err_d = res_err_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        base_a_d = cmd_base_a;
        base_b_d = cmd_base_b;
        len_d    = cmd_len;
        idx_d    = '0;
        err_d    = 1'b0;
        state_d  = CLEAR;
      end
      CLEAR: state_d = (len_q == '0) ? DONE : FETCH;
      FETCH: state_d = LOAD;
      LOAD: begin
        a_d     = mem_rdata_a;
        b_d     = mem_rdata_b;
        state_d = START;
      end
      START: state_d = WAIT;
      WAIT: begin
        wcnt_d = wcnt_q + 1'b1;
        // the first WAIT cycle may still see ready from the previous operation
        if (wcnt_q != '0 && mac_ready) state_d = SETTLE;
        else if (wcnt_d == WW'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      SETTLE: if (idx_q == len_q - 1'b1) state_d = DONE;
              else begin
                idx_d   = idx_q + 1'b1;
                state_d = FETCH;
              end
      DONE: state_d = result_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) state_d = IDLE;
    // a zero-length run reports the freshly cleared accumulator
    if (state_d == DONE && state_q != DONE) begin
      res_d     = (state_q == CLEAR) ? '0 : mac_acc;
      res_err_d = err_d;
    end
  end

  assign cmd_ready    = state_q == IDLE;
  assign busy         = state_q != IDLE;
  assign mem_rd_en    = state_q == FETCH && !abort;
  assign mac_start    = state_q == START && !abort;
  assign mac_clr_acc  = state_q == CLEAR;
  assign mem_addr_a   = base_a_q + idx_q[ADDR_WIDTH-1:0];
  assign mem_addr_b   = base_b_q + idx_q[ADDR_WIDTH-1:0];
  assign mac_a        = a_q;
  assign mac_b        = b_q;
  assign result_valid = state_q == DONE;
  assign result_data  = res_q;
  assign result_err   = res_err_q;
endmodule

// File: tb/tb_mac_dot_seq.sv
// tb_mac_dot_seq: random and directed runs against a behavioural MAC/memory model,
// with results checked by a scoreboard monitor on the result handshake.
module tb_mac_dot_seq;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, abort = 1'b0;
  logic [7:0]  cmd_base_a = '0, cmd_base_b = '0;
  logic [8:0]  cmd_len = '0;
  logic        mem_rd_en;
  logic [7:0]  mem_addr_a, mem_addr_b;
  logic [15:0] mem_rdata_a = '0, mem_rdata_b = '0;
  logic        mac_start, mac_clr_acc, mac_ready;
  logic [15:0] mac_a, mac_b;
  logic [39:0] mac_acc;
  logic        result_valid, result_ready = 1'b1, result_err, busy;
  logic [39:0] result_data;

  always #5 clk = ~clk;

  mac_dot_seq dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base_a(cmd_base_a), .cmd_base_b(cmd_base_b), .cmd_len(cmd_len), .abort(abort),
    .mem_rd_en(mem_rd_en), .mem_addr_a(mem_addr_a), .mem_addr_b(mem_addr_b),
    .mem_rdata_a(mem_rdata_a), .mem_rdata_b(mem_rdata_b), .mac_start(mac_start),
    .mac_clr_acc(mac_clr_acc), .mac_a(mac_a), .mac_b(mac_b), .mac_ready(mac_ready),
    .mac_acc(mac_acc), .result_valid(result_valid), .result_ready(result_ready),
    .result_data(result_data), .result_err(result_err), .busy(busy)
  );

  logic signed [15:0] mem_a [256];
  logic signed [15:0] mem_b [256];
  always @(posedge clk) if (mem_rd_en) begin
    mem_rdata_a <= mem_a[mem_addr_a];
    mem_rdata_b <= mem_b[mem_addr_b];
  end

  // behavioural mac_top: random latency, ready drops on start and rises with the update
  logic signed [39:0] acc;
  logic               mrdy, tie0 = 1'b0;
  int                 mcnt;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin acc <= '0; mrdy <= 1'b1; mcnt <= 0; end
    else if (mac_clr_acc) begin acc <= '0; mrdy <= 1'b1; mcnt <= 0; end
    else if (mac_start) begin mrdy <= 1'b0; mcnt <= $urandom_range(1, 4); end
    else if (mcnt == 1) begin acc <= acc + $signed(mac_a) * $signed(mac_b); mrdy <= 1'b1; mcnt <= 0; end
    else if (mcnt > 1) mcnt <= mcnt - 1;
  assign mac_acc   = acc;
  assign mac_ready = mrdy & ~tie0;

  int checks = 0, fails = 0;
  int n_start = 0, n_clr = 0, n_rd = 0, cyc = 0, t_start = 0, t_rv = 0;
  logic rv_prev = 1'b0, rec_addr = 1'b0, rand_rdy = 1'b0;
  logic [40:0] exp_q [$];
  logic [15:0] addr_q [$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) if (rst_n) begin
    logic [40:0] e;
    if (result_valid && result_ready) begin
      if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("result_data", 64'(result_data), 64'(e[39:0]));
        chk("result_err", 64'(result_err), 64'(e[40]));
      end
    end
    if (mac_start && mac_clr_acc) chk("start_clr_overlap", 1, 0);
    if (mac_start) begin n_start++; t_start = cyc; end
    if (mac_clr_acc) n_clr++;
    if (mem_rd_en) n_rd++;
    if (mem_rd_en && rec_addr) addr_q.push_back({mem_addr_a, mem_addr_b});
    if (result_valid && !rv_prev) t_rv = cyc;
    rv_prev = result_valid;
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_rdy) result_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [39:0] dot(int ba, int bb, int len);
    longint s = 0;
    for (int i = 0; i < len; i++)
      s += longint'(mem_a[(ba + i) % 256]) * longint'(mem_b[(bb + i) % 256]);
    return s[39:0];
  endfunction

  task automatic issue(int ba, int bb, int len);
    int n = 0;
    while (!cmd_ready && n < 100) begin @(posedge clk); #1; n++; end
    cmd_base_a = 8'(ba); cmd_base_b = 8'(bb); cmd_len = 9'(len); cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    while (busy && n < 6000) begin @(posedge clk); #1; n++; end
    chk({name, "_done_in_time"}, 64'(busy), 0);
  endtask

  task automatic chk_idle_outputs(string t);
    chk({t, "_cmd_ready"}, 64'(cmd_ready), 1);
    chk({t, "_busy"}, 64'(busy), 0);
    chk({t, "_result_valid"}, 64'(result_valid), 0);
    chk({t, "_mac_start"}, 64'(mac_start), 0);
    chk({t, "_mac_clr_acc"}, 64'(mac_clr_acc), 0);
    chk({t, "_mem_rd_en"}, 64'(mem_rd_en), 0);
    chk({t, "_mem_addr_a"}, 64'(mem_addr_a), 0);
    chk({t, "_mac_a"}, 64'(mac_a), 0);
    chk({t, "_result_data"}, 64'(result_data), 0);
    chk({t, "_result_err"}, 64'(result_err), 0);
  endtask

  task automatic func_case(string t);
    int s0, c0;
    mem_a[0] = 10; mem_a[1] = 2;  mem_a[2] = 100;
    mem_b[0] = 5;  mem_b[1] = -3; mem_b[2] = 10;
    s0 = n_start; c0 = n_clr;
    exp_q.push_back({1'b0, 40'd1044});
    issue(0, 0, 3);
    wait_idle(t);
    chk({t, "_starts"}, 64'(n_start - s0), 3);
    chk({t, "_clears"}, 64'(n_clr - c0), 1);
  endtask

  initial begin
    int s0, c0, r0, n;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 16'($urandom);
      mem_b[i] = 16'($urandom);
    end
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    func_case("func");

    s0 = n_start; c0 = n_clr; r0 = n_rd;
    exp_q.push_back({1'b0, 40'd0});
    issue(5, 9, 0);
    wait_idle("zero_len");
    chk("zero_len_starts", 64'(n_start - s0), 0);
    chk("zero_len_clears", 64'(n_clr - c0), 1);
    chk("zero_len_reads", 64'(n_rd - r0), 0);

    mem_a[20] = -300; mem_b[40] = 7;
    tie0 = 1'b1;
    s0 = n_start;
    exp_q.push_back({1'b1, 40'hFF_FFFF_F7CC});
    issue(20, 40, 2);
    wait_idle("timeout");
    tie0 = 1'b0;
    chk("timeout_starts", 64'(n_start - s0), 1);
    chk("timeout_latency", 64'(t_rv - t_start), 65);

    result_ready = 1'b0;
    addr_q.delete();
    rec_addr = 1'b1;
    exp_q.push_back({1'b0, dot(254, 16, 4)});
    issue(254, 16, 4);
    n = 0;
    while (!result_valid && n < 200) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid_held", 64'(result_valid), 1);
      chk("bp_data_stable", 64'(result_data), 64'(dot(254, 16, 4)));
      chk("bp_cmd_ready", 64'(cmd_ready), 0);
      @(posedge clk); #1;
    end
    result_ready = 1'b1;
    wait_idle("wrap");
    rec_addr = 1'b0;
    chk("wrap_reads", 64'(addr_q.size()), 4);
    for (int i = 0; i < 4 && i < addr_q.size(); i++)
      chk("wrap_addr", 64'(addr_q[i]), 64'({8'(254 + i), 8'(16 + i)}));

    s0 = n_start;
    issue(30, 60, 3);
    n = 0;
    while (n_start < s0 + 2 && n < 200) begin @(posedge clk); #1; n++; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_cmd_ready", 64'(cmd_ready), 1);
    chk("abort_busy", 64'(busy), 0);
    chk("abort_result_valid", 64'(result_valid), 0);
    repeat (6) @(posedge clk);
    #1;
    mem_a[50] = 7; mem_b[70] = 6;
    exp_q.push_back({1'b0, 40'd42});
    issue(50, 70, 1);
    wait_idle("after_abort");

    mem_a[0] = 10; mem_a[1] = 2; mem_a[2] = 100;
    mem_b[0] = 5;  mem_b[1] = -3; mem_b[2] = 10;
    exp_q.push_back({1'b0, 40'd1044});
    issue(0, 0, 3);
    n = 0;
    while (!mem_rd_en && n < 50) begin @(posedge clk); #1; n++; end
    #2 rst_n = 1'b0;
    #1;
    chk_idle_outputs("mid_reset");
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    func_case("func_after_reset");

    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 16'($urandom);
      mem_b[i] = 16'($urandom);
    end
    rand_rdy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      int ba, bb, len;
      ba = $urandom_range(0, 255);
      bb = $urandom_range(0, 255);
      len = (k == 9) ? 256 : $urandom_range(1, 8);
      exp_q.push_back({1'b0, dot(ba, bb, len)});
      issue(ba, bb, len);
      wait_idle("random");
    end
    rand_rdy = 1'b0;
    result_ready = 1'b1;
    @(posedge clk); #1;
    chk("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
